// File: rtl/mod_add_sub_pipe.sv
// mod_add_sub_pipe: LANES parallel modular add/sub butterflies mod Q,
// with an optional halving step (inverse transform mode), two register stages.
// Optional feature: define MOD_ADD_SUB_RANGE_CHK_EN to add the out_err port,
// which flags lanes whose operands were >= Q when the beat was accepted.
//
// Handshake (both ports): a beat transfers on a rising edge where valid and
// ready are both high; valid never depends on ready, and the producer may
// change or drop a beat that was not transferred. in_ready is combinational
// from out_ready so the pipe runs at one beat per cycle with no bubbles.
module mod_add_sub_pipe #(
  parameter int W     = 12,
  parameter int Q     = 3329,
  parameter int LANES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_mode,
  input  logic [LANES*W-1:0] in_a,
  input  logic [LANES*W-1:0] in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*W-1:0] out_sum,
  output logic [LANES*W-1:0] out_diff
`ifdef MOD_ADD_SUB_RANGE_CHK_EN
  ,
  output logic [LANES-1:0]   out_err
`endif
);

  // Signed intermediate width: a+b of two W-bit values plus a sign bit.
  localparam int SW = W + 2;
  localparam logic signed [SW-1:0] QS = SW'(Q);

  logic                 s1_valid;
  logic                 s1_mode;
  logic signed [SW-1:0] s1_sum  [LANES];
  logic signed [SW-1:0] s1_diff [LANES];
  logic                 s2_valid;
  logic                 s2_load;
  logic                 s1_adv;
  logic                 in_fire;
  logic [LANES*W-1:0]   red_sum;
  logic [LANES*W-1:0]   red_diff;

  // Bring a raw sum/difference into [0,Q-1]; in inverse mode also multiply
  // by inv2 = (Q+1)/2, done as "make even by adding Q, then shift right".
  function automatic logic [W-1:0] reduce(input logic signed [SW-1:0] v,
                                          input logic mode);
    logic signed [SW-1:0] r;
    r = v;
    if (r < 0) r = r + QS;
    else if (r >= QS) r = r - QS;
    if (mode) begin
      if (r[0]) r = r + QS;
      r = r >>> 1;
    end
    return r[W-1:0];
  endfunction

  // Stage 2 loads when empty or when its beat leaves this cycle.
  assign s2_load   = !s2_valid || out_ready;
  assign s1_adv    = s1_valid && s2_load;
  assign in_ready  = !s1_valid || s1_adv;
  assign in_fire   = in_valid && in_ready;
  assign out_valid = s2_valid;

  // Stage 1: capture raw signed a+b and a-b per lane together with the mode.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_mode  <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        s1_sum[i]  <= '0;
        s1_diff[i] <= '0;
      end
    end else begin
      if (in_fire) begin
        s1_valid <= 1'b1;
        s1_mode  <= in_mode;
        for (int i = 0; i < LANES; i++) begin
          s1_sum[i]  <= $signed({2'b00, in_a[i*W +: W]}) + $signed({2'b00, in_b[i*W +: W]});
          s1_diff[i] <= $signed({2'b00, in_a[i*W +: W]}) - $signed({2'b00, in_b[i*W +: W]});
        end
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // Modular reduction / halving of the stage-1 contents, per lane.
  always_comb begin
    red_sum  = '0;
    red_diff = '0;
    for (int i = 0; i < LANES; i++) begin
      red_sum[i*W +: W]  = reduce(s1_sum[i], s1_mode);
      red_diff[i*W +: W] = reduce(s1_diff[i], s1_mode);
    end
  end

  // Stage 2: output registers; they hold while the downstream stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      out_sum  <= '0;
      out_diff <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_sum  <= red_sum;
        out_diff <= red_diff;
      end
    end
  end

`ifdef MOD_ADD_SUB_RANGE_CHK_EN
  logic [LANES-1:0] s1_err;

  // Range flags ride alongside their beat through both stages.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_err  <= '0;
      out_err <= '0;
    end else begin
      if (in_fire) begin
        for (int i = 0; i < LANES; i++) begin
          s1_err[i] <= (in_a[i*W +: W] >= W'(Q)) || (in_b[i*W +: W] >= W'(Q));
        end
      end
      if (s2_load && s1_valid) out_err <= s1_err;
    end
  end
`endif

endmodule

// File: doc/mod_add_sub_pipe.md
MOD_ADD_SUB_PIPE -- requirements
Module: mod_add_sub_pipe

Interface
REQ-001 Parameter W, default 12: coefficient width in bits.
REQ-002 Parameter Q, default 3329: modulus; odd, 2 < Q < 2^W.
REQ-003 Parameter LANES, default 4: number of independent butterflies processed in parallel.
REQ-004 Port clk  input  1: single clock; all state updates on the rising edge.
REQ-005 Port rst_n  input  1: reset, synchronous, active-low.
REQ-006 Port in_valid  input  1: the input beat is valid.
REQ-007 Port in_ready  output  1: the block accepts the input beat this cycle.
REQ-008 Port in_mode  input  1: 0 = forward (NTT) add/sub, 1 = inverse (INTT) add/sub with halving.
REQ-009 Port in_a  input  LANES*W: operand a; lane i occupies bits [i*W +: W].
REQ-010 Port in_b  input  LANES*W: operand b; packed the same way as in_a.
REQ-011 Port out_valid  output  1: the output beat is valid.
REQ-012 Port out_ready  input  1: the downstream block accepts the output beat.
REQ-013 Port out_sum  output  LANES*W: per-lane sum result.
REQ-014 Port out_diff  output  LANES*W: per-lane difference result.

Function
REQ-015 Operands are in [0,Q-1]; behaviour for out-of-range operands is undefined unless MOD_ADD_SUB_RANGE_CHK_EN is set.
REQ-016 Mode 0: sum = (a+b) mod Q; diff = (a-b) mod Q; both in [0,Q-1].
REQ-017 Mode 1: sum = (a+b)*inv2 mod Q; diff = (a-b)*inv2 mod Q, where inv2 = (Q+1)/2.
REQ-018 Mode 1 halving: reduce the value to [0,Q-1] first; if it is odd, add Q; then shift right by 1.
REQ-019 Intermediate arithmetic is W+2 bits signed; no overflow for any legal W and Q.
REQ-020 Pipeline: 2 register stages; stage 1 holds the raw signed a+b and a-b plus the mode; stage 2 holds the reduced or halved results.
REQ-021 Latency: a beat accepted in cycle n appears on the outputs in cycle n+2 if no stall occurs.
REQ-022 Throughput: 1 beat per cycle while out_ready=1.
REQ-023 Each stage has its own valid bit; a stage loads when it is empty or when its content moves on in the same cycle.
REQ-024 in_ready = !stage1_valid | stage1_advances; it is combinational from out_ready.
REQ-025 A transfer occurs on in_valid & in_ready; out_valid = stage2_valid.
REQ-026 While out_valid=1 and out_ready=0, out_sum, out_diff and out_valid hold stable.
REQ-027 Under a stall, up to 2 beats are buffered with no loss or reordering; in_ready drops once both stages are full.
REQ-028 Mode is captured per beat; consecutive beats may alternate modes without a bubble.
REQ-029 When in_valid=0, in_a, in_b and in_mode are ignored.

Reset
REQ-030 On a clk edge with rst_n=0: both stage valid bits clear, out_valid=0, out_sum=0 and out_diff=0.
REQ-031 in_ready=1 during the first cycle after reset release.
REQ-032 A reset asserted mid-stream discards all in-flight beats; no partial beat is emitted afterwards.

Configuration
REQ-033 Macro MOD_ADD_SUB_RANGE_CHK_EN defined: add output port out_err (LANES bits); bit i=1 when lane i's a or b was >= Q at acceptance.
REQ-034 With the macro, out_err travels with its beat, has the same latency and stall behaviour, and resets to 0.
REQ-035 Without the macro: no out_err port and no range-check logic.

Verification (W=12, Q=3329, LANES=4)
REQ-036 Mode 0, all lanes a=3000, b=1000, out_ready=1 -> 2 cycles later sum=671, diff=2000.
REQ-037 Mode 1, lane0 a=1,b=0; lane1 a=3328,b=3328; lane2 a=0,b=1; lane3 a=2,b=2 -> sums 1665,3328,1665,2; diffs 1665,0,1664,0.
REQ-038 Three back-to-back beats with out_ready=0 for 4 cycles -> in_ready=0 after 2 beats accepted; 3rd beat held off; all three emerge in order once out_ready=1.
REQ-039 Beats alternating mode 0/1 with identical operands a=5,b=2 -> outputs alternate (7,3) and (1668,1666) at full rate.
REQ-040 rst_n low for 1 cycle while both stages are full -> out_valid=0 next cycle, the in-flight beats are never emitted, and in_ready=1.
REQ-041 MOD_ADD_SUB_RANGE_CHK_EN defined, lane2 a=3329 -> out_err=4'b0100 with that beat only.
